// File: rtl/tawas_ls_load_wb.sv
// Load-return writeback sequencer: issues word reads for accepted loads,
// aligns/extends the returned data and writes it back in order, in the
// register-file write slot of the thread that issued the load.
module tawas_ls_load_wb #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        SLICE,

    input  logic        LD_REQ_VLD,
    output logic        LD_REQ_RDY,
    input  logic        LD_REQ_THREAD,
    input  logic [2:0]  LD_REQ_SEL,
    input  logic [31:0] LD_REQ_ADDR,
    input  logic [1:0]  LD_REQ_SIZE,
    input  logic        LD_REQ_SIGNED,

    output logic        DBUS_RD_REQ,
    output logic [31:0] DBUS_RD_ADDR,
    input  logic        DBUS_RD_ACK,
    input  logic        DBUS_RD_DVLD,
    input  logic [31:0] DBUS_RD_DATA,

    output logic        LS_LOAD_VLD,
    output logic [2:0]  LS_LOAD_SEL,
    output logic [31:0] LS_LOAD,
    output logic [1:0]  LD_BUSY
);

    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned DATA_W = 32;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;

    // One in-flight load: identity, alignment info and returned data.
    typedef struct packed {
        logic              valid;
        logic              thread;
        logic [2:0]        sel;
        logic [1:0]        size;
        logic              sgn;
        logic [1:0]        off;
        logic [DATA_W-1:0] data;
        logic              done;
    } entry_t;

    entry_t            ent_q [DEPTH];
    logic [PTR_W-1:0]  alloc_ptr;
    logic [PTR_W-1:0]  resp_ptr;
    logic [PTR_W-1:0]  wb_ptr;
    logic [CNT_W-1:0]  count;
    logic              req_q;
    logic [DATA_W-1:0] addr_q;

    entry_t            head_c;
    entry_t            resp_ent_c;
    logic              accept_c;
    logic              rsp_c;
    logic              wb_c;

    // Select the returned byte/half/word and extend it to a full register.
    function automatic logic [DATA_W-1:0] align_data(
        input logic [DATA_W-1:0] d,
        input logic [1:0]        size,
        input logic              sgn,
        input logic [1:0]        off
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (size)
            SIZE_BYTE: align_data = {{24{sgn & b[7]}}, b};
            SIZE_HALF: align_data = {{16{sgn & h[15]}}, h};
            default:   align_data = d;
        endcase
    endfunction

    assign head_c     = ent_q[wb_ptr];
    assign resp_ent_c = ent_q[resp_ptr];

    // Accept needs a free entry and a bus request slot that is empty or draining.
    assign LD_REQ_RDY = RST_N & (count < DEPTH_C) & (~req_q | DBUS_RD_ACK);
    assign accept_c   = LD_REQ_VLD & LD_REQ_RDY;

    // The oldest allocated-but-not-returned entry is the only legal target of DVLD.
    assign rsp_c      = DBUS_RD_DVLD & resp_ent_c.valid & ~resp_ent_c.done;
    assign wb_c       = LS_LOAD_VLD;

    assign DBUS_RD_REQ  = req_q;
    assign DBUS_RD_ADDR = addr_q;

    // Bus request holds until ACK; a same-cycle accept re-arms it with the new address.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            req_q  <= 1'b0;
            addr_q <= '0;
        end else if (accept_c) begin
            req_q  <= 1'b1;
            addr_q <= {LD_REQ_ADDR[31:2], 2'b00};
        end else if (DBUS_RD_ACK) begin
            req_q  <= 1'b0;
        end
    end

    // Entry storage: allocate on accept, fill on response, retire on writeback.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[PTR_W'(i)] <= '0;
            end
        end else begin
            if (accept_c) begin
                ent_q[alloc_ptr].valid  <= 1'b1;
                ent_q[alloc_ptr].thread <= LD_REQ_THREAD;
                ent_q[alloc_ptr].sel    <= LD_REQ_SEL;
                ent_q[alloc_ptr].size   <= LD_REQ_SIZE;
                ent_q[alloc_ptr].sgn    <= LD_REQ_SIGNED;
                ent_q[alloc_ptr].off    <= LD_REQ_ADDR[1:0];
                ent_q[alloc_ptr].data   <= '0;
                ent_q[alloc_ptr].done   <= 1'b0;
            end
            if (rsp_c) begin
                ent_q[resp_ptr].data <= align_data(DBUS_RD_DATA, resp_ent_c.size,
                                                   resp_ent_c.sgn, resp_ent_c.off);
                ent_q[resp_ptr].done <= 1'b1;
            end
            if (wb_c) begin
                ent_q[wb_ptr].valid <= 1'b0;
                ent_q[wb_ptr].done  <= 1'b0;
            end
        end
    end

    // Circular-buffer pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            alloc_ptr <= '0;
            resp_ptr  <= '0;
            wb_ptr    <= '0;
            count     <= '0;
        end else begin
            if (accept_c) begin
                alloc_ptr <= alloc_ptr + PTR_W'(1);
            end
            if (rsp_c) begin
                resp_ptr <= resp_ptr + PTR_W'(1);
            end
            if (wb_c) begin
                wb_ptr <= wb_ptr + PTR_W'(1);
            end
            case ({accept_c, wb_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Writeback only from a completed head entry, in the other thread's slice.
    always_comb begin
        LS_LOAD_VLD = 1'b0;
        LS_LOAD_SEL = '0;
        LS_LOAD     = '0;
        if (head_c.valid & head_c.done & (head_c.thread != SLICE)) begin
            LS_LOAD_VLD = 1'b1;
            LS_LOAD_SEL = head_c.sel;
            LS_LOAD     = head_c.data;
        end
    end

    // Per-thread busy flags for load-use stalls.
    always_comb begin
        LD_BUSY = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_q[PTR_W'(i)].valid) begin
                LD_BUSY[ent_q[PTR_W'(i)].thread] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tawas_ls_load_wb.sv
// Directed bench for tawas_ls_load_wb with an in-order queue model.
module tb_tawas_ls_load_wb;

    localparam int unsigned DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        SLICE = 1'b0;
    logic        LD_REQ_VLD = 1'b0;
    logic        LD_REQ_RDY;
    logic        LD_REQ_THREAD = 1'b0;
    logic [2:0]  LD_REQ_SEL = '0;
    logic [31:0] LD_REQ_ADDR = '0;
    logic [1:0]  LD_REQ_SIZE = '0;
    logic        LD_REQ_SIGNED = 1'b0;
    logic        DBUS_RD_REQ;
    logic [31:0] DBUS_RD_ADDR;
    logic        DBUS_RD_ACK = 1'b0;
    logic        DBUS_RD_DVLD = 1'b0;
    logic [31:0] DBUS_RD_DATA = '0;
    logic        LS_LOAD_VLD;
    logic [2:0]  LS_LOAD_SEL;
    logic [31:0] LS_LOAD;
    logic [1:0]  LD_BUSY;

    tawas_ls_load_wb #(.DEPTH(4), .PTR_W(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .SLICE(SLICE),
        .LD_REQ_VLD(LD_REQ_VLD), .LD_REQ_RDY(LD_REQ_RDY),
        .LD_REQ_THREAD(LD_REQ_THREAD), .LD_REQ_SEL(LD_REQ_SEL),
        .LD_REQ_ADDR(LD_REQ_ADDR), .LD_REQ_SIZE(LD_REQ_SIZE),
        .LD_REQ_SIGNED(LD_REQ_SIGNED),
        .DBUS_RD_REQ(DBUS_RD_REQ), .DBUS_RD_ADDR(DBUS_RD_ADDR),
        .DBUS_RD_ACK(DBUS_RD_ACK), .DBUS_RD_DVLD(DBUS_RD_DVLD),
        .DBUS_RD_DATA(DBUS_RD_DATA),
        .LS_LOAD_VLD(LS_LOAD_VLD), .LS_LOAD_SEL(LS_LOAD_SEL),
        .LS_LOAD(LS_LOAD), .LD_BUSY(LD_BUSY)
    );

    initial forever #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    // Model: queue of loads in issue order; the first m_rsp of them have data.
    typedef struct {
        logic        thr;
        logic [2:0]  sel;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  off;
        logic [31:0] data;
        logic        done;
    } ld_t;

    ld_t         mq[$];
    int          m_rsp = 0;
    logic        m_req = 1'b0;
    logic [31:0] m_addr = '0;
    logic        m_a;
    logic        m_w;
    ld_t         m_e;

    function automatic logic [31:0] m_align(input logic [31:0] d, input logic [1:0] sz,
                                            input logic sg, input logic [1:0] off);
        logic [31:0] sh;
        if (sz >= 2'd2) return d;
        if (sz == 2'd0) begin
            sh = d >> (8 * int'(off));
            return sg ? 32'($signed(sh[7:0])) : 32'(sh[7:0]);
        end
        sh = d >> (16 * int'(off[1]));
        return sg ? 32'($signed(sh[15:0])) : 32'(sh[15:0]);
    endfunction

    function automatic logic e_rdy();
        return RST_N && (mq.size() < int'(DEPTH)) && (!m_req || DBUS_RD_ACK);
    endfunction

    function automatic logic e_vld();
        return (mq.size() > 0) && mq[0].done && (mq[0].thr != SLICE);
    endfunction

    function automatic logic [1:0] e_busy();
        logic [1:0] b = '0;
        foreach (mq[i]) b[mq[i].thr] = 1'b1;
        return b;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mq.delete();
            m_rsp  = 0;
            m_req  = 1'b0;
            m_addr = '0;
        end else begin
            m_a = LD_REQ_VLD && e_rdy();
            m_w = e_vld();
            if (DBUS_RD_DVLD && (m_rsp < mq.size())) begin
                m_e      = mq[m_rsp];
                m_e.data = m_align(DBUS_RD_DATA, m_e.size, m_e.sgn, m_e.off);
                m_e.done = 1'b1;
                mq[m_rsp] = m_e;
                m_rsp++;
            end
            if (m_w) begin
                void'(mq.pop_front());
                m_rsp--;
            end
            if (m_a) begin
                m_e.thr  = LD_REQ_THREAD;
                m_e.sel  = LD_REQ_SEL;
                m_e.size = LD_REQ_SIZE;
                m_e.sgn  = LD_REQ_SIGNED;
                m_e.off  = LD_REQ_ADDR[1:0];
                m_e.data = '0;
                m_e.done = 1'b0;
                mq.push_back(m_e);
                m_req  = 1'b1;
                m_addr = {LD_REQ_ADDR[31:2], 2'b00};
            end else if (DBUS_RD_ACK) begin
                m_req = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic v;
        v = e_vld();
        chk("rdy", 32'(LD_REQ_RDY), 32'(e_rdy()));
        chk("req", 32'(DBUS_RD_REQ), 32'(m_req));
        chk("addr", DBUS_RD_ADDR, m_addr);
        chk("ld_vld", 32'(LS_LOAD_VLD), 32'(v));
        chk("ld_sel", 32'(LS_LOAD_SEL), v ? 32'(mq[0].sel) : 32'd0);
        chk("ld_data", LS_LOAD, v ? mq[0].data : 32'd0);
        chk("busy", 32'(LD_BUSY), 32'(e_busy()));
    endtask

    task automatic tick();
        @(negedge CLK);
        check_all();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input logic v, input logic thr, input logic [2:0] sel,
                           input logic [31:0] addr, input logic [1:0] size, input logic sg);
        LD_REQ_VLD    = v;
        LD_REQ_THREAD = thr;
        LD_REQ_SEL    = sel;
        LD_REQ_ADDR   = addr;
        LD_REQ_SIZE   = size;
        LD_REQ_SIGNED = sg;
    endtask

    task automatic set_bus(input logic ack, input logic dv, input logic [31:0] d);
        DBUS_RD_ACK  = ack;
        DBUS_RD_DVLD = dv;
        DBUS_RD_DATA = d;
    endtask

    task automatic single_load(input logic thr, input logic [2:0] sel, input logic [31:0] addr,
                               input logic [1:0] size, input logic sg, input logic [31:0] d,
                               input logic [31:0] exp);
        set_req(1'b1, thr, sel, addr, size, sg);
        tick();
        set_req(1'b0, 1'b0, 3'd0, 32'd0, 2'd0, 1'b0);
        set_bus(1'b1, 1'b0, 32'd0);
        tick();
        set_bus(1'b0, 1'b1, d);
        tick();
        set_bus(1'b0, 1'b0, 32'd0);
        SLICE = ~thr;
        #1;
        chk("ext_vld", 32'(LS_LOAD_VLD), 32'd1);
        chk("ext_data", LS_LOAD, exp);
        tick();
    endtask

    bit       bv [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    bit       bt [11] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    bit [2:0] bs [11] = '{1, 2, 3, 4, 5, 5, 5, 0, 0, 0, 0};
    bit       bd [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
    bit       bl [11] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_rdy", 32'(LD_REQ_RDY), 32'd0);
        chk("rst_req", 32'(DBUS_RD_REQ), 32'd0);
        chk("rst_addr", DBUS_RD_ADDR, 32'd0);
        chk("rst_vld", 32'(LS_LOAD_VLD), 32'd0);
        chk("rst_sel", 32'(LS_LOAD_SEL), 32'd0);
        chk("rst_data", LS_LOAD, 32'd0);
        chk("rst_busy", 32'(LD_BUSY), 32'd0);
        RST_N = 1'b1;
        #1;
        chk("rdy_after_rst", 32'(LD_REQ_RDY), 32'd1);
        tick();

        // Word load, T0
        SLICE = 1'b0;
        set_req(1'b1, 1'b0, 3'd3, 32'h0000_1004, 2'd2, 1'b0);
        tick();
        set_req(1'b0, 1'b0, 3'd0, 32'd0, 2'd0, 1'b0);
        set_bus(1'b1, 1'b0, 32'd0);
        #1;
        chk("w_req", 32'(DBUS_RD_REQ), 32'd1);
        chk("w_addr", DBUS_RD_ADDR, 32'h0000_1004);
        chk("w_busy", 32'(LD_BUSY), 32'd1);
        tick();
        set_bus(1'b0, 1'b1, 32'hDEAD_BEEF);
        #1;
        chk("w_req_drop", 32'(DBUS_RD_REQ), 32'd0);
        tick();
        set_bus(1'b0, 1'b0, 32'd0);
        #1;
        chk("w_wrong_slice", 32'(LS_LOAD_VLD), 32'd0);
        tick();
        SLICE = 1'b1;
        #1;
        chk("w_vld", 32'(LS_LOAD_VLD), 32'd1);
        chk("w_sel", 32'(LS_LOAD_SEL), 32'd3);
        chk("w_data", LS_LOAD, 32'hDEAD_BEEF);
        chk("w_busy_held", 32'(LD_BUSY), 32'd1);
        tick();
        chk("w_busy_clr", 32'(LD_BUSY), 32'd0);
        chk("w_vld_clr", 32'(LS_LOAD_VLD), 32'd0);
        tick();

        // Alignment and extension
        single_load(1'b1, 3'd1, 32'h0000_2001, 2'd0, 1'b1, 32'h8A7F_80FF, 32'hFFFF_FF80);
        single_load(1'b0, 3'd2, 32'h0000_2003, 2'd0, 1'b0, 32'h8A7F_80FF, 32'h0000_008A);
        single_load(1'b1, 3'd3, 32'h0000_2002, 2'd1, 1'b1, 32'h8A7F_80FF, 32'hFFFF_8A7F);
        single_load(1'b0, 3'd4, 32'h0000_2000, 2'd1, 1'b0, 32'h8A7F_80FF, 32'h0000_80FF);
        single_load(1'b1, 3'd5, 32'h0000_2000, 2'd0, 1'b1, 32'h8A7F_80FF, 32'hFFFF_FFFF);
        single_load(1'b0, 3'd6, 32'h0000_2003, 2'd1, 1'b0, 32'h8A7F_80FF, 32'h0000_8A7F);
        single_load(1'b1, 3'd7, 32'h0000_2003, 2'd2, 1'b1, 32'h8A7F_80FF, 32'h8A7F_80FF);

        // Back-to-back with ACK tied high; fifth request waits for a free entry
        for (int i = 0; i < 11; i++) begin
            set_req(bv[i], bt[i], bs[i], 32'h100 + 32'(4 * ((i < 4) ? i : 4)), 2'd2, 1'b0);
            set_bus(1'b1, bd[i], 32'hA000_0000 + 32'(i));
            SLICE = bl[i];
            #1;
            if (i >= 1 && i <= 4) chk("b2b_req", 32'(DBUS_RD_REQ), 32'd1);
            if (i == 4) chk("b2b_full_rdy", 32'(LD_REQ_RDY), 32'd0);
            if (i == 5) begin
                chk("b2b_req_drop", 32'(DBUS_RD_REQ), 32'd0);
                chk("b2b_rdy_still0", 32'(LD_REQ_RDY), 32'd0);
                chk("b2b_wb1_sel", 32'(LS_LOAD_SEL), 32'd1);
                chk("b2b_wb1_data", LS_LOAD, 32'hA000_0004);
            end
            if (i == 6) begin
                chk("b2b_rdy_back", 32'(LD_REQ_RDY), 32'd1);
                chk("b2b_wb2_sel", 32'(LS_LOAD_SEL), 32'd2);
            end
            tick();
        end
        set_bus(1'b0, 1'b0, 32'd0);
        tick();

        // Head-of-line blocking
        SLICE = 1'b0;
        set_req(1'b1, 1'b0, 3'd6, 32'h0000_0200, 2'd2, 1'b0);
        tick();
        set_req(1'b1, 1'b1, 3'd7, 32'h0000_0204, 2'd2, 1'b0);
        set_bus(1'b1, 1'b0, 32'd0);
        tick();
        set_req(1'b0, 1'b0, 3'd0, 32'd0, 2'd0, 1'b0);
        set_bus(1'b1, 1'b1, 32'h600D_0006);
        tick();
        set_bus(1'b0, 1'b1, 32'h600D_0007);
        tick();
        set_bus(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hol_blocked", 32'(LS_LOAD_VLD), 32'd0);
            tick();
        end
        SLICE = 1'b1;
        #1;
        chk("hol_t0_sel", 32'(LS_LOAD_SEL), 32'd6);
        chk("hol_t0_data", LS_LOAD, 32'h600D_0006);
        tick();
        SLICE = 1'b0;
        #1;
        chk("hol_t1_sel", 32'(LS_LOAD_SEL), 32'd7);
        chk("hol_t1_data", LS_LOAD, 32'h600D_0007);
        tick();
        chk("hol_busy_clr", 32'(LD_BUSY), 32'd0);
        tick();

        // Bus stall: ACK low for three cycles
        SLICE = 1'b1;
        set_req(1'b1, 1'b1, 3'd1, 32'h0000_3008, 2'd2, 1'b0);
        tick();
        set_req(1'b1, 1'b0, 3'd2, 32'h0000_300C, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_req", 32'(DBUS_RD_REQ), 32'd1);
            chk("stall_addr", DBUS_RD_ADDR, 32'h0000_3008);
            chk("stall_rdy", 32'(LD_REQ_RDY), 32'd0);
            tick();
        end
        set_bus(1'b1, 1'b0, 32'd0);
        #1;
        chk("stall_rdy_ack", 32'(LD_REQ_RDY), 32'd1);
        tick();
        set_req(1'b0, 1'b0, 3'd0, 32'd0, 2'd0, 1'b0);
        #1;
        chk("stall_addr2", DBUS_RD_ADDR, 32'h0000_300C);
        tick();
        set_bus(1'b0, 1'b1, 32'h1111_2222);
        tick();
        set_bus(1'b0, 1'b1, 32'h3333_4444);
        SLICE = 1'b0;
        tick();
        set_bus(1'b0, 1'b0, 32'd0);
        SLICE = 1'b1;
        tick();
        tick();

        // Reset with two loads outstanding
        set_req(1'b1, 1'b0, 3'd1, 32'h0000_0400, 2'd2, 1'b0);
        tick();
        set_req(1'b1, 1'b1, 3'd2, 32'h0000_0404, 2'd2, 1'b0);
        set_bus(1'b1, 1'b0, 32'd0);
        tick();
        set_req(1'b0, 1'b0, 3'd0, 32'd0, 2'd0, 1'b0);
        set_bus(1'b0, 1'b0, 32'd0);
        #1;
        chk("pre_rst_busy", 32'(LD_BUSY), 32'd3);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(LD_REQ_RDY), 32'd0);
        chk("mid_rst_req", 32'(DBUS_RD_REQ), 32'd0);
        chk("mid_rst_addr", DBUS_RD_ADDR, 32'd0);
        chk("mid_rst_vld", 32'(LS_LOAD_VLD), 32'd0);
        chk("mid_rst_sel", 32'(LS_LOAD_SEL), 32'd0);
        chk("mid_rst_data", LS_LOAD, 32'd0);
        chk("mid_rst_busy", 32'(LD_BUSY), 32'd0);
        tick();
        RST_N = 1'b1;
        tick();
        set_bus(1'b0, 1'b1, 32'hBAD0_BAD0);
        tick();
        set_bus(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            SLICE = ~SLICE;
            #1;
            chk("stray_vld", 32'(LS_LOAD_VLD), 32'd0);
            chk("stray_busy", 32'(LD_BUSY), 32'd0);
            tick();
        end
        chk("post_rst_rdy", 32'(LD_REQ_RDY), 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
